// File: rtl/store_buffer_coalesce.sv
// Byte-granular store buffer: circular FIFO of committed stores with optional
// same-word coalescing, store-to-load forwarding and a req/ack drain FSM.
module store_buffer_coalesce #(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 32,
  parameter int DEPTH    = 4,
  parameter int COALESCE = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         st_valid_i,
  input  logic [ADDR_LEN-1:0]          st_addr_i,
  input  logic [XLEN-1:0]              st_data_i,
  input  logic [1:0]                   st_size_i,
  output logic                         st_ready_o,
  input  logic                         ld_valid_i,
  input  logic [ADDR_LEN-1:0]          ld_addr_i,
  input  logic [1:0]                   ld_size_i,
  output logic                         fwd_hit_o,
  output logic [XLEN-1:0]              fwd_data_o,
  output logic                         fwd_stall_o,
  input  logic                         drain_en_i,
  input  logic                         fence_i,
  output logic                         drain_req_o,
  output logic [ADDR_LEN-1:0]          drain_addr_o,
  output logic [XLEN-1:0]              drain_data_o,
  output logic [XLEN/8-1:0]            drain_be_o,
  input  logic                         drain_ack_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int WAW  = ADDR_LEN - OFFW;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  function automatic logic [NB-1:0] lane_mask(input logic [1:0] size, input logic [OFFW-1:0] off);
    logic [NB-1:0] base;
    base = '0;
    case (size)
      2'd0:    base[0]   = 1'b1;
      2'd1:    base[1:0] = 2'b11;
      default: base[3:0] = 4'hF;
    endcase
    return base << off;
  endfunction

  function automatic logic [XLEN-1:0] bytes_to_bits(input logic [NB-1:0] m);
    logic [XLEN-1:0] bits;
    for (int b = 0; b < NB; b++) bits[8*b +: 8] = {8{m[b]}};
    return bits;
  endfunction

  logic [DEPTH-1:0] ent_valid;
  logic [WAW-1:0]   ent_waddr [DEPTH];
  logic [XLEN-1:0]  ent_data  [DEPTH];
  logic [NB-1:0]    ent_mask  [DEPTH];

  logic [PW-1:0]   head, tail, tail_m1;
  logic [CW-1:0]   count;
  state_t          state, state_next;

  logic [OFFW-1:0] st_off, ld_off;
  logic [WAW-1:0]  st_waddr, ld_waddr;
  logic [NB-1:0]   st_mask;
  logic [XLEN-1:0] st_data_sh;
  logic            full, merge, push, push_new, push_merge, pop;

  assign st_off     = st_addr_i[OFFW-1:0];
  assign st_waddr   = st_addr_i[ADDR_LEN-1:OFFW];
  assign ld_off     = ld_addr_i[OFFW-1:0];
  assign ld_waddr   = ld_addr_i[ADDR_LEN-1:OFFW];
  assign st_mask    = lane_mask(st_size_i, st_off);
  assign st_data_sh = (st_data_i & bytes_to_bits(lane_mask(st_size_i, '0))) << {st_off, 3'b000};
  assign tail_m1    = tail - PW'(1);

  // The head entry is frozen once presented to the dcache, so it never merges.
  assign merge      = (COALESCE != 0) && (count != '0) && ent_valid[tail_m1] &&
                      (ent_waddr[tail_m1] == st_waddr) &&
                      !((state == S_REQ) && (tail_m1 == head));
  assign full       = (count == CW'(DEPTH));
  assign st_ready_o = ~full | merge;
  assign push       = st_valid_i & st_ready_o;
  assign push_new   = push & ~merge;
  assign push_merge = push & merge;
  assign pop        = (state == S_REQ) & drain_ack_i;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_next = state;
    case (state)
      S_IDLE: if ((count != '0) && (drain_en_i | fence_i)) state_next = S_REQ;
      S_REQ:  if (drain_ack_i)
                state_next = ((count > CW'(1)) && (drain_en_i | fence_i)) ? S_REQ : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      state <= state_next;
      count <= count + CW'(push_new) - CW'(pop);
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PW'(1);
      end
      if (push_new) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PW'(1);
      end
    end
  end

  // NOTE: entry payload is not reset; the valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (push_new) begin
      ent_waddr[tail] <= st_waddr;
      ent_data[tail]  <= st_data_sh;
      ent_mask[tail]  <= st_mask;
    end else if (push_merge) begin
      for (int b = 0; b < NB; b++)
        if (st_mask[b]) ent_data[tail_m1][8*b +: 8] <= st_data_sh[8*b +: 8];
      ent_mask[tail_m1] <= ent_mask[tail_m1] | st_mask;
    end
  end

  logic [PW-1:0]   fwd_idx;
  logic [NB-1:0]   found, needed, covered;
  logic [XLEN-1:0] fwd_word;

  // Walk oldest to youngest so a younger entry overwrites an older byte.
  always_comb begin
    fwd_idx  = head;
    found    = '0;
    fwd_word = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head + PW'(k);
      if (ent_valid[fwd_idx] && (ent_waddr[fwd_idx] == ld_waddr)) begin
        for (int b = 0; b < NB; b++) begin
          if (ent_mask[fwd_idx][b]) begin
            found[b]          = 1'b1;
            fwd_word[8*b +: 8] = ent_data[fwd_idx][8*b +: 8];
          end
        end
      end
    end
    needed      = ld_valid_i ? lane_mask(ld_size_i, ld_off) : '0;
    covered     = found & needed;
    fwd_hit_o   = (needed != '0) && (covered == needed);
    fwd_stall_o = (covered != '0) && !fwd_hit_o;
    fwd_data_o  = fwd_hit_o ? ((fwd_word >> {ld_off, 3'b000}) &
                               bytes_to_bits(lane_mask(ld_size_i, '0))) : '0;
  end

  assign drain_req_o  = (state == S_REQ);
  assign drain_addr_o = drain_req_o ? {ent_waddr[head], {OFFW{1'b0}}} : '0;
  assign drain_data_o = drain_req_o ? ent_data[head] : '0;
  assign drain_be_o   = drain_req_o ? ent_mask[head] : '0;

  assign count_o = count;
  assign full_o  = full;
  assign empty_o = (count == '0);

endmodule

// File: tb/tb_store_buffer_coalesce.sv
// Directed bench for store_buffer_coalesce: coalescing, back-pressure, drain
// ordering, forwarding hit/stall, fence draining and reset mid-request.
module tb_store_buffer_coalesce;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        fwd_stall;
  logic        drain_en;
  logic        fence;
  logic        drain_req;
  logic [31:0] drain_addr;
  logic [31:0] drain_data;
  logic [3:0]  drain_be;
  logic        drain_ack;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int checks   = 0;
  int failures = 0;

  store_buffer_coalesce dut (
    .clk          (clk),
    .reset        (reset),
    .st_valid_i   (st_valid),
    .st_addr_i    (st_addr),
    .st_data_i    (st_data),
    .st_size_i    (st_size),
    .st_ready_o   (st_ready),
    .ld_valid_i   (ld_valid),
    .ld_addr_i    (ld_addr),
    .ld_size_i    (ld_size),
    .fwd_hit_o    (fwd_hit),
    .fwd_data_o   (fwd_data),
    .fwd_stall_o  (fwd_stall),
    .drain_en_i   (drain_en),
    .fence_i      (fence),
    .drain_req_o  (drain_req),
    .drain_addr_o (drain_addr),
    .drain_data_o (drain_data),
    .drain_be_o   (drain_be),
    .drain_ack_i  (drain_ack),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus sanity: stores must be naturally aligned.
  always @(negedge clk) begin
    if (!reset && st_valid) begin
      assert ((st_size == 2'd0) ||
              (st_size == 2'd1 && st_addr[0] == 1'b0) ||
              (st_size == 2'd2 && st_addr[1:0] == 2'b00))
      else begin
        failures++;
        $error("FAIL misaligned_store: addr=0x%0h size=%0d", st_addr, st_size);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic drain_all(input string tag);
    fence     = 1'b1;
    drain_ack = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (empty) break;
      tick();
    end
    fence     = 1'b0;
    drain_ack = 1'b0;
    #1;
    check(tag, empty, 1'b1);
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_size = '0;
    drain_en = 1'b0; fence = 1'b0; drain_ack = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("rst_ready", st_ready, 1'b1);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_count", count, 3'd0);
    check("rst_req", drain_req, 1'b0);
    check("rst_be", drain_be, 4'h0);

    // 1: two byte stores to one word coalesce into one entry
    put_store(32'h100, 32'hAB, 2'd0);
    st_valid = 1'b1; st_addr = 32'h101; st_data = 32'hCD; st_size = 2'd0;
    #1;
    check("t1_merge_ready", st_ready, 1'b1);
    tick();
    st_valid = 1'b0;
    #1;
    check("t1_count", count, 3'd1);
    check("t1_no_req", drain_req, 1'b0);
    drain_en = 1'b1;
    tick();
    check("t1_req", drain_req, 1'b1);
    check("t1_addr", drain_addr, 32'h100);
    check("t1_data", drain_data, 32'h0000CDAB);
    check("t1_be", drain_be, 4'b0011);
    drain_ack = 1'b1;
    tick();
    drain_ack = 1'b0; drain_en = 1'b0;
    #1;
    check("t1_empty", empty, 1'b1);
    check("t1_idle", drain_req, 1'b0);

    // 2: fill, back-pressure, in-order drain
    for (int i = 0; i < 4; i++) put_store(32'(i * 16), 32'hA000_0000 | 32'(i), 2'd2);
    #1;
    check("t2_full", full, 1'b1);
    check("t2_count", count, 3'd4);
    st_valid = 1'b1; st_addr = 32'h40; st_data = 32'hA4; st_size = 2'd2;
    #1;
    check("t2_refuse", st_ready, 1'b0);
    st_valid = 1'b0;
    drain_en = 1'b1;
    tick();
    check("t2_req", drain_req, 1'b1);
    check("t2_addr0", drain_addr, 32'h0);
    check("t2_data0", drain_data, 32'hA000_0000);
    drain_ack = 1'b1;
    st_valid  = 1'b1;
    #1;
    check("t2_refuse_on_ack", st_ready, 1'b0);
    tick();
    st_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      #1;
      check($sformatf("t2_addr%0d", i), drain_addr, 32'(i * 16));
      check($sformatf("t2_data%0d", i), drain_data, 32'hA000_0000 | 32'(i));
      tick();
    end
    drain_ack = 1'b0;
    #1;
    check("t2_drained", empty, 1'b1);
    check("t2_idle", drain_req, 1'b0);
    st_valid = 1'b1; st_addr = 32'h40; st_data = 32'hA4; st_size = 2'd2;
    #1;
    check("t2_fifth_ready", st_ready, 1'b1);
    tick();
    st_valid = 1'b0;
    #1;
    check("t2_fifth_count", count, 3'd1);
    tick();
    check("t2_fifth_addr", drain_addr, 32'h40);
    check("t2_fifth_data", drain_data, 32'hA4);
    drain_ack = 1'b1;
    tick();
    drain_ack = 1'b0; drain_en = 1'b0;
    #1;
    check("t2_final_empty", empty, 1'b1);

    // 3: full and partial-width forwarding hits
    put_store(32'h200, 32'h1122_3344, 2'd2);
    ld_valid = 1'b1; ld_addr = 32'h200; ld_size = 2'd2;
    #1;
    check("t3_lw_hit", fwd_hit, 1'b1);
    check("t3_lw_stall", fwd_stall, 1'b0);
    check("t3_lw_data", fwd_data, 32'h1122_3344);
    ld_addr = 32'h202; ld_size = 2'd1;
    #1;
    check("t3_lh_hit", fwd_hit, 1'b1);
    check("t3_lh_data", fwd_data, 32'h0000_1122);
    ld_addr = 32'h204; ld_size = 2'd2;
    #1;
    check("t3_miss_hit", fwd_hit, 1'b0);
    check("t3_miss_stall", fwd_stall, 1'b0);
    ld_valid = 1'b0; ld_addr = 32'h200;
    #1;
    check("t3_novalid_hit", fwd_hit, 1'b0);
    drain_all("t3_drain");

    // 4: partial overlap stalls, cleared once the entry drains
    put_store(32'h300, 32'h55, 2'd0);
    ld_valid = 1'b1; ld_addr = 32'h300; ld_size = 2'd2;
    #1;
    check("t4_stall", fwd_stall, 1'b1);
    check("t4_nohit", fwd_hit, 1'b0);
    check("t4_data0", fwd_data, 32'h0);
    drain_en = 1'b1;
    tick();
    check("t4_req", drain_req, 1'b1);
    check("t4_stall_in_req", fwd_stall, 1'b1);
    drain_ack = 1'b1;
    tick();
    drain_ack = 1'b0; drain_en = 1'b0;
    #1;
    check("t4_after_hit", fwd_hit, 1'b0);
    check("t4_after_stall", fwd_stall, 1'b0);
    ld_valid = 1'b0;

    // 5: head in REQ blocks coalescing; younger data wins the forward
    drain_en = 1'b1;
    put_store(32'h400, 32'hAAAA_0001, 2'd2);
    tick();
    check("t5_req", drain_req, 1'b1);
    st_valid = 1'b1; st_addr = 32'h400; st_data = 32'hBBBB_0002; st_size = 2'd2;
    #1;
    check("t5_ready", st_ready, 1'b1);
    tick();
    st_valid = 1'b0; drain_en = 1'b0;
    #1;
    check("t5_count", count, 3'd2);
    ld_valid = 1'b1; ld_addr = 32'h400; ld_size = 2'd2;
    #1;
    check("t5_hit", fwd_hit, 1'b1);
    check("t5_young_data", fwd_data, 32'hBBBB_0002);
    check("t5_head_stable", drain_data, 32'hAAAA_0001);
    ld_valid = 1'b0;
    drain_all("t5_drain");

    // 6: fence drains with drain_en low; reset cancels an in-flight request
    for (int k = 0; k < 3; k++) put_store(32'h500 + 32'(k * 16), 32'h5000 + 32'(k), 2'd2);
    #1;
    check("t6_count", count, 3'd3);
    check("t6_no_req", drain_req, 1'b0);
    fence = 1'b1;
    tick();
    check("t6_fence_req", drain_req, 1'b1);
    drain_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t6_addr%0d", k), drain_addr, 32'h500 + 32'(k * 16));
      tick();
    end
    drain_ack = 1'b0; fence = 1'b0;
    #1;
    check("t6_empty", empty, 1'b1);
    check("t6_idle", drain_req, 1'b0);
    put_store(32'h600, 32'h6, 2'd2);
    put_store(32'h610, 32'h7, 2'd2);
    fence = 1'b1;
    tick();
    check("t6_req_before_rst", drain_req, 1'b1);
    reset = 1'b1;
    tick();
    check("t6_rst_req", drain_req, 1'b0);
    check("t6_rst_count", count, 3'd0);
    check("t6_rst_empty", empty, 1'b1);
    check("t6_rst_ready", st_ready, 1'b1);
    reset = 1'b0; fence = 1'b0;
    tick();
    check("t6_post_req", drain_req, 1'b0);
    check("t6_post_count", count, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
